io_bank_ctrl: RTL and testbench
===============================

IO_BANK_CTRL -- requirements
Module: io_bank_ctrl

Interface
REQ-001 Parameter C_NUM_OF_PIN, default 1, pin count, legal range 1..32.
REQ-002 Parameter C_SYNC_STAGES, default 2, input synchroniser depth, legal range 2..4.
REQ-003 Parameter C_FILTER_WIDTH, default 4, width of filt_len and of each per-pin filter counter, legal range 1..16.
REQ-004 aclk  input  1  sole clock; all state on rising edge.
REQ-005 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 lo  input  C_NUM_OF_PIN  logic-side output data.
REQ-007 lt  input  C_NUM_OF_PIN  logic-side tristate control, 1 = high-Z.
REQ-008 li  output  C_NUM_OF_PIN  synchronised, filtered pin input.
REQ-009 ro  output  C_NUM_OF_PIN  pad output data, registered.
REQ-010 rt  output  C_NUM_OF_PIN  pad tristate control, registered.
REQ-011 ri  input  C_NUM_OF_PIN  raw asynchronous pad input.
REQ-012 filt_len  input  C_FILTER_WIDTH  glitch-filter length in cycles; 0 = filter bypass.
REQ-013 irq_rise_en  input  C_NUM_OF_PIN  per-pin rising-edge capture enable.
REQ-014 irq_fall_en  input  C_NUM_OF_PIN  per-pin falling-edge capture enable.
REQ-015 irq_clr  input  C_NUM_OF_PIN  per-pin single-cycle status clear pulse.
REQ-016 irq_status  output  C_NUM_OF_PIN  sticky per-pin edge status.
REQ-017 irq  output  1  OR-reduction of irq_status.

Function
REQ-018 Output path: ro and rt shall equal lo and lt delayed by exactly one aclk cycle.
REQ-019 Input path: each ri bit shall pass through a C_SYNC_STAGES flip-flop chain; the last stage is the pin's sync value.
REQ-020 Filter: per pin, when sync equals li the counter shall clear to 0; when sync differs from li and counter < filt_len, the counter shall increment.
REQ-021 Filter: when sync differs from li and counter >= filt_len, li shall load sync and the counter shall clear to 0.
REQ-022 The ">=" compare applies when filt_len is lowered mid-count: the update then occurs on the next cycle.
REQ-023 Latency: a clean ri transition held stable shall appear on li exactly C_SYNC_STAGES + filt_len + 1 cycles later.
REQ-024 A sync pulse shorter than filt_len + 1 cycles shall not change li, and its counter shall restart at 0.
REQ-025 Edge detect: on the cycle li changes 0->1 with irq_rise_en set, or 1->0 with irq_fall_en set, irq_status for that pin shall be set; visible in the same cycle as the new li.
REQ-026 irq_status shall remain set until cleared by irq_clr.
REQ-027 An irq_clr bit shall clear the pin's status on the next cycle.
REQ-028 When a set event and irq_clr occur in the same cycle, set shall win.
REQ-029 Disabling irq_rise_en or irq_fall_en shall not clear existing status.
REQ-030 irq shall be combinational OR of the irq_status registers (glitch-free, register-sourced).
REQ-031 Pins are fully independent; no cross-pin interaction.

Reset
REQ-032 While aresetn is low: ro = 0, rt = all ones (all pads high-Z), synchroniser stages = 0, li = 0, counters = 0, irq_status = 0, irq = 0.
REQ-033 Assertion of aresetn mid-filter-count shall discard the count.
REQ-034 After release, a pad held high shall be reported as a rising edge (li 0->1) after the normal latency.
REQ-035 Reset deassertion shall be synchronised externally; the block needs no internal reset synchroniser.

Structure
REQ-036 The shared package io_bank_pkg shall hold C_MAX_PINS = 32, the parameter defaults, and the reset constants (RT_RESET = 1, RO_RESET = 0).
REQ-037 Per-pin logic (synchroniser, filter counter, edge detect, status bit) shall be one sub-module, io_bank_pin, instantiated C_NUM_OF_PIN times by generate.

Verification
REQ-038 N=8, filt_len=0: drive lo=0xA5, lt=0x0F -> ro=0xA5, rt=0x0F one cycle later; after reset rt=0xFF, ro=0x00.
REQ-039 N=4, SYNC=2, filt_len=3: ri[0] 0->1 held -> li[0] rises exactly 6 cycles later; a 3-cycle ri[0] pulse -> li unchanged, counter back to 0.
REQ-040 irq_rise_en=0x1, irq_fall_en=0x0: ri[0] rise then fall -> irq_status=0x1 from the rise only, irq=1; irq_clr=0x1 pulse -> status 0 next cycle.
REQ-041 irq_clr[2] pulsed in the same cycle as a qualifying li[2] edge -> irq_status[2]=1 afterwards.
REQ-042 filt_len=10 with count at 6, then filt_len changed to 2 -> li updates on the next cycle.
REQ-043 aresetn asserted mid-count with ri=1 held -> all outputs reset; after release, li rises after C_SYNC_STAGES+filt_len+1 cycles and rising status sets if enabled.

Source files
------------

// File: rtl/io_bank_pkg.sv
// io_bank_pkg
// Shared constants for the IO bank controller: pin-count ceiling, parameter
// defaults, pad reset levels, and a small edge-qualification helper used by
// every per-pin slice.
package io_bank_pkg;

    localparam int C_MAX_PINS             = 32;
    localparam int C_DEF_NUM_OF_PIN       = 1;
    localparam int C_DEF_SYNC_STAGES      = 2;
    localparam int C_DEF_FILTER_WIDTH     = 4;

    // Pads come out of reset released (high-Z) and driving low underneath.
    localparam logic RT_RESET = 1'b1;
    localparam logic RO_RESET = 1'b0;

    // An accepted li transition to new_level is reportable when the enable
    // for that direction is set.
    function automatic logic edge_qualifies(input logic new_level,
                                            input logic rise_en,
                                            input logic fall_en);
        return new_level ? rise_en : fall_en;
    endfunction

endpackage

// File: rtl/io_bank_pin.sv
// io_bank_pin
// One pad's input path: C_SYNC_STAGES-deep synchroniser, glitch filter that
// accepts a new level only after it has disagreed with li for filt_len+1
// consecutive cycles, and a sticky edge-status bit.
// Ports:
//   aclk, aresetn  clock, async active-low reset
//   ri             raw asynchronous pad input
//   filt_len       filter length in cycles (0 = accept after one cycle)
//   rise_en/fall_en  edge capture enables
//   clr            single-cycle status clear
//   li             filtered input level
//   status         sticky edge status
module io_bank_pin
    import io_bank_pkg::*;
#(
    parameter int C_SYNC_STAGES  = C_DEF_SYNC_STAGES,
    parameter int C_FILTER_WIDTH = C_DEF_FILTER_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      ri,
    input  logic [C_FILTER_WIDTH-1:0] filt_len,
    input  logic                      rise_en,
    input  logic                      fall_en,
    input  logic                      clr,
    output logic                      li,
    output logic                      status
);

    logic [C_SYNC_STAGES-1:0]  sync_reg;
    logic [C_FILTER_WIDTH-1:0] cnt_reg;
    logic                      li_reg;
    logic                      status_reg;

    logic sync;
    logic differ;
    logic load;
    logic edge_set;

    assign sync   = sync_reg[C_SYNC_STAGES-1];
    assign differ = sync ^ li_reg;
    // ">=" rather than "==" so that lowering filt_len below the running
    // count still lets the pending level through on the next cycle.
    assign load     = differ && (cnt_reg >= filt_len);
    // Status is set on the same edge that li takes its new value.
    assign edge_set = load && edge_qualifies(sync, rise_en, fall_en);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_reg   <= '0;
            cnt_reg    <= '0;
            li_reg     <= 1'b0;
            status_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[C_SYNC_STAGES-2:0], ri};
            if (!differ) begin
                cnt_reg <= '0;
            end else if (load) begin
                li_reg  <= sync;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + C_FILTER_WIDTH'(1);
            end
            // Set has priority over a coincident clear.
            status_reg <= edge_set | (status_reg & ~clr);
        end
    end

    assign li     = li_reg;
    assign status = status_reg;

endmodule

// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl
// Bank of C_NUM_OF_PIN independent bidirectional pads. The output path
// registers lo/lt onto ro/rt; the input path synchronises and filters ri
// onto li and records qualifying edges in sticky irq_status bits.
// Ports:
//   aclk, aresetn        clock, async active-low reset
//   lo, lt               logic-side output data / tristate (1 = high-Z)
//   ro, rt               registered pad output data / tristate
//   ri                   raw pad input
//   li                   synchronised, filtered input
//   filt_len             glitch-filter length (0 = bypass)
//   irq_rise_en/fall_en  per-pin edge capture enables
//   irq_clr              per-pin status clear pulse
//   irq_status, irq      sticky status and its OR-reduction
module io_bank_ctrl
    import io_bank_pkg::*;
#(
    parameter int C_NUM_OF_PIN   = C_DEF_NUM_OF_PIN,
    parameter int C_SYNC_STAGES  = C_DEF_SYNC_STAGES,
    parameter int C_FILTER_WIDTH = C_DEF_FILTER_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [C_NUM_OF_PIN-1:0]   lo,
    input  logic [C_NUM_OF_PIN-1:0]   lt,
    output logic [C_NUM_OF_PIN-1:0]   li,
    output logic [C_NUM_OF_PIN-1:0]   ro,
    output logic [C_NUM_OF_PIN-1:0]   rt,
    input  logic [C_NUM_OF_PIN-1:0]   ri,
    input  logic [C_FILTER_WIDTH-1:0] filt_len,
    input  logic [C_NUM_OF_PIN-1:0]   irq_rise_en,
    input  logic [C_NUM_OF_PIN-1:0]   irq_fall_en,
    input  logic [C_NUM_OF_PIN-1:0]   irq_clr,
    output logic [C_NUM_OF_PIN-1:0]   irq_status,
    output logic                      irq
);

    logic [C_NUM_OF_PIN-1:0] ro_reg;
    logic [C_NUM_OF_PIN-1:0] rt_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ro_reg <= {C_NUM_OF_PIN{RO_RESET}};
            rt_reg <= {C_NUM_OF_PIN{RT_RESET}};
        end else begin
            ro_reg <= lo;
            rt_reg <= lt;
        end
    end

    assign ro = ro_reg;
    assign rt = rt_reg;

    generate
        for (genvar gi = 0; gi < C_NUM_OF_PIN; gi++) begin : g_pin
            io_bank_pin #(
                .C_SYNC_STAGES  (C_SYNC_STAGES),
                .C_FILTER_WIDTH (C_FILTER_WIDTH)
            ) u_pin (
                .aclk     (aclk),
                .aresetn  (aresetn),
                .ri       (ri[gi]),
                .filt_len (filt_len),
                .rise_en  (irq_rise_en[gi]),
                .fall_en  (irq_fall_en[gi]),
                .clr      (irq_clr[gi]),
                .li       (li[gi]),
                .status   (irq_status[gi])
            );
        end
    endgenerate

    // Driven only by status flops, so irq cannot glitch.
    assign irq = |irq_status;

endmodule

// File: tb/tb_io_bank_ctrl.sv
module tb_io_bank_ctrl;

    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int FW   = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [N-1:0]  lo, lt, li, ro, rt, ri;
    logic [FW-1:0] filt_len;
    logic [N-1:0]  irq_rise_en, irq_fall_en, irq_clr, irq_status;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    io_bank_ctrl #(
        .C_NUM_OF_PIN   (N),
        .C_SYNC_STAGES  (SYNC),
        .C_FILTER_WIDTH (FW)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .lo          (lo),
        .lt          (lt),
        .li          (li),
        .ro          (ro),
        .rt          (rt),
        .ri          (ri),
        .filt_len    (filt_len),
        .irq_rise_en (irq_rise_en),
        .irq_fall_en (irq_fall_en),
        .irq_clr     (irq_clr),
        .irq_status  (irq_status),
        .irq         (irq)
    );

    // Reference model: ri reaches the filter SYNC sampled cycles late; a
    // pin's filtered level follows the synchronised level once the two
    // have disagreed for more than filt_len consecutive cycles.
    logic [N-1:0] hist_m [SYNC];   // hist_m[0] = most recently sampled ri
    logic [N-1:0] li_m, st_m, ro_m, rt_m;
    int           run_m [N];       // consecutive disagreeing cycles so far

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SYNC; s++) hist_m[s] = '0;
        li_m = '0;
        st_m = '0;
        ro_m = '0;
        rt_m = '1;
        for (int p = 0; p < N; p++) run_m[p] = 0;
    endtask

    // Caller drives inputs at the falling edge, then calls step(): one
    // rising edge, model update from the sampled inputs, compare, and
    // return at the next falling edge.
    task automatic step();
        logic [N-1:0] sync_v;
        logic [N-1:0] set_v;
        @(posedge aclk);
        sync_v = hist_m[SYNC-1];
        set_v  = '0;
        for (int p = 0; p < N; p++) begin
            if (sync_v[p] != li_m[p]) begin
                run_m[p] = run_m[p] + 1;
                if (run_m[p] > int'(filt_len)) begin
                    li_m[p]  = sync_v[p];
                    run_m[p] = 0;
                    if ((sync_v[p] && irq_rise_en[p]) || (!sync_v[p] && irq_fall_en[p]))
                        set_v[p] = 1'b1;
                end
            end else begin
                run_m[p] = 0;
            end
        end
        st_m = set_v | (st_m & ~irq_clr);
        for (int s = SYNC - 1; s > 0; s--) hist_m[s] = hist_m[s-1];
        hist_m[0] = ri;
        ro_m = lo;
        rt_m = lt;
        #1;
        check_val("li", li, li_m);
        check_val("ro", ro, ro_m);
        check_val("rt", rt, rt_m);
        check_val("irq_status", irq_status, st_m);
        check_val("irq", irq, |st_m);
        @(negedge aclk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until li[pin] reaches level; returns the step count or 0.
    task automatic measure(input int pin, input logic level, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (lat == 0 && li[pin] == level) lat = i;
        end
    endtask

    initial begin
        int lat;
        logic seen;
        aresetn     = 1'b0;
        lo          = '0;
        lt          = '0;
        ri          = '0;
        filt_len    = '0;
        irq_rise_en = '0;
        irq_fall_en = '0;
        irq_clr     = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge aclk);
        check_val("rst_ro", ro, 8'h00);
        check_val("rst_rt", rt, 8'hFF);
        check_val("rst_li", li, 8'h00);
        check_val("rst_status", irq_status, 8'h00);
        check_val("rst_irq", irq, 1'b0);
        aresetn = 1'b1;

        // Output path
        lo = 8'hA5;
        lt = 8'h0F;
        step();
        $display("tx out: lo=a5 lt=0f -> ro=%0h rt=%0h", ro, rt);
        check_val("out_ro", ro, 8'hA5);
        check_val("out_rt", rt, 8'h0F);

        // Latency with filt_len=3
        filt_len = 4'd3;
        ri[0] = 1'b1;
        measure(0, 1'b1, lat);
        $display("tx rise latency pin0: %0d", lat);
        check_val("lat_rise", lat, 6);

        // Short pulse must be swallowed, and the count must restart
        ri[0] = 1'b0;
        steps(8);
        ri[0] = 1'b1;
        steps(3);
        ri[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (li[0]) seen = 1'b1;
        end
        $display("tx 3-cycle pulse pin0: li seen high=%0b", seen);
        check_val("pulse_li", seen, 1'b0);
        ri[0] = 1'b1;
        measure(0, 1'b1, lat);
        $display("tx rise after pulse pin0: %0d", lat);
        check_val("lat_after_pulse", lat, 6);

        // Rise-only capture and clear
        irq_rise_en = 8'h01;
        irq_fall_en = 8'h00;
        ri[0] = 1'b0;
        steps(8);
        check_val("fall_no_status", irq_status, 8'h00);
        ri[0] = 1'b1;
        steps(8);
        check_val("rise_status", irq_status, 8'h01);
        check_val("rise_irq", irq, 1'b1);
        ri[0] = 1'b0;
        steps(8);
        check_val("fall_keeps_status", irq_status, 8'h01);
        irq_clr = 8'h01;
        step();
        irq_clr = 8'h00;
        $display("tx clr pin0: status=%0h irq=%0b", irq_status, irq);
        check_val("clr_status", irq_status, 8'h00);
        check_val("clr_irq", irq, 1'b0);

        // Set beats a coincident clear
        irq_rise_en = 8'h05;
        ri[2] = 1'b1;
        steps(5);
        check_val("pre_edge_li2", li[2], 1'b0);
        irq_clr = 8'h04;
        step();
        irq_clr = 8'h00;
        $display("tx set+clr pin2: li=%0h status=%0h", li, irq_status);
        check_val("setclr_li2", li[2], 1'b1);
        check_val("setclr_status2", irq_status[2], 1'b1);

        // Lowering filt_len mid-count
        filt_len = 4'd10;
        ri[1] = 1'b1;
        steps(8);
        check_val("long_filt_li1", li[1], 1'b0);
        filt_len = 4'd2;
        step();
        $display("tx filt_len 10->2 pin1: li=%0h", li);
        check_val("lowered_li1", li[1], 1'b1);

        // Reset mid-count
        filt_len = 4'd3;
        irq_rise_en = 8'h0D;
        ri[3] = 1'b1;
        steps(4);
        aresetn = 1'b0;
        #1;
        check_val("mid_rst_ro", ro, 8'h00);
        check_val("mid_rst_rt", rt, 8'hFF);
        check_val("mid_rst_li", li, 8'h00);
        check_val("mid_rst_status", irq_status, 8'h00);
        check_val("mid_rst_irq", irq, 1'b0);
        model_reset();
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        measure(3, 1'b1, lat);
        $display("tx post-reset rise pin3: %0d status=%0h", lat, irq_status);
        check_val("rst_lat_rise3", lat, 6);
        check_val("rst_status3", irq_status[3], 1'b1);

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++)
                if ($urandom_range(5) == 0) ri[p] = ~ri[p];
            lo = N'($urandom);
            lt = N'($urandom);
            if ($urandom_range(15) == 0) filt_len = FW'($urandom_range(5));
            if ($urandom_range(7) == 0) irq_rise_en = N'($urandom);
            if ($urandom_range(7) == 0) irq_fall_en = N'($urandom);
            irq_clr = ($urandom_range(3) == 0) ? N'($urandom) : '0;
            step();
            $display("tx rnd %0d: ri=%0h fl=%0d li=%0h st=%0h", c, ri, filt_len, li, irq_status);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
